// File: rtl/afifo_wr_arbiter_if.sv
// Producer-side bundle for the AFIFO write arbiter: NREQ valid/ready/last
// request lanes plus the single AFIFO write port (wpush/wdata/wfull).
// master = producers + FIFO environment, slave = the arbiter.
interface afifo_wr_arbiter_if #(
  parameter int NREQ     = 4,
  parameter int DATASIZE = 8
);
  logic [NREQ-1:0]               req_valid;
  logic [NREQ-1:0][DATASIZE-1:0] req_data;
  logic [NREQ-1:0]               req_last;
  logic [NREQ-1:0]               req_ready;
  logic                          wfull;
  logic                          wpush;
  logic [DATASIZE-1:0]           wdata;

  modport master (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, wpush, wdata
  );

  modport slave (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, wpush, wdata
  );
endinterface

// File: rtl/afifo_wr_arbiter.sv
// Round-robin arbiter sharing the AFIFO write port between NREQ producers.
// A grant lasts one packet (ends on req_last) or MAX_BURST words, whichever
// comes first. One IDLE cycle is spent on every arbitration decision.

// Per-requester slice: gates the handshake and masks data/last so the top
// can merge all lanes with a plain OR.
module afifo_wr_arbiter_lane #(
  parameter int DATASIZE = 8
) (
  input  logic                sel,
  input  logic                busy,
  input  logic                valid,
  input  logic                last,
  input  logic                wfull,
  input  logic [DATASIZE-1:0] data,
  output logic                ready,
  output logic                push,
  output logic                last_m,
  output logic [DATASIZE-1:0] data_m
);
  assign ready  = sel & busy & ~wfull;
  assign push   = ready & valid;
  assign last_m = sel & last;
  assign data_m = sel ? data : '0;
endmodule

module afifo_wr_arbiter #(
  parameter  int NREQ      = 4,
  parameter  int DATASIZE  = 8,
  parameter  int MAX_BURST = 8,
  localparam int IDW       = $clog2(NREQ)
) (
  input  logic               wclk,
  input  logic               wrst_n,
  afifo_wr_arbiter_if.slave  bus,
  output logic [IDW-1:0]     grant_id,
  output logic               busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                        state, state_nxt;
  logic [IDW-1:0]                rr_ptr, rr_nxt, grant_nxt, pick, owner_inc;
  logic [7:0]                    burst_cnt, burst_nxt;
  logic [IDW:0]                  cand;
  logic                          any_valid, xfer, rel;
  logic [NREQ-1:0]               sel, ready_v, push_v, last_v;
  logic [NREQ-1:0][DATASIZE-1:0] data_v;
  logic [DATASIZE-1:0]           wdata_c;

  assign busy = (state == GRANT);

  // per-lane handshake gating; only the owner's lane can be non-zero
  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign sel[g] = (grant_id == IDW'(g));
    afifo_wr_arbiter_lane #(.DATASIZE(DATASIZE)) u_lane (
      .sel    (sel[g]),
      .busy   (busy),
      .valid  (bus.req_valid[g]),
      .last   (bus.req_last[g]),
      .wfull  (bus.wfull),
      .data   (bus.req_data[g]),
      .ready  (ready_v[g]),
      .push   (push_v[g]),
      .last_m (last_v[g]),
      .data_m (data_v[g])
    );
  end

  // merge lanes; grant_id survives into IDLE, so wdata follows the last owner
  always_comb begin
    wdata_c = '0;
    for (int i = 0; i < NREQ; i++) wdata_c = wdata_c | data_v[i];
  end

  assign bus.req_ready = ready_v;
  assign bus.wpush     = |push_v;
  assign bus.wdata     = wdata_c;

  assign xfer      = bus.wpush;
  assign rel       = xfer & ((|last_v) | (burst_cnt == 8'(MAX_BURST - 1)));
  assign any_valid = |bus.req_valid;
  assign owner_inc = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  // round-robin search upward from rr_ptr with wrap; lowest offset wins
  always_comb begin
    pick = rr_ptr;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDW + 1)'(k);
      if (cand >= (IDW + 1)'(NREQ)) cand = cand - (IDW + 1)'(NREQ);
      if (bus.req_valid[cand[IDW-1:0]]) pick = cand[IDW-1:0];
    end
  end

  // next-state: grant in IDLE, count/release in GRANT
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    rr_nxt    = rr_ptr;
    burst_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (any_valid) begin
          grant_nxt = pick;
          burst_nxt = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (xfer) burst_nxt = burst_cnt + 8'd1;
        if (rel) begin
          state_nxt = IDLE;
          rr_nxt    = owner_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register, async active-low reset
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      grant_id  <= grant_nxt;
      burst_cnt <= burst_nxt;
    end
  end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Bench for afifo_wr_arbiter: per-producer word queues drive the request
// lanes, a transaction-level reference (owner / words-in-grant / next search
// start) predicts every cycle, and directed scenarios check grant order.
module tb_afifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int MB    = 8;
  localparam int DEPTH = 16;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic [1:0] grant_id;
  logic       busy;

  afifo_wr_arbiter_if #(.NREQ(NREQ), .DATASIZE(DW)) bus ();

  afifo_wr_arbiter #(.NREQ(NREQ), .DATASIZE(DW), .MAX_BURST(MB)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 wclk = ~wclk;

  int passed = 0;
  int total  = 0;

  // producers and FIFO environment
  logic [DW-1:0] qd[NREQ][$];
  bit            ql[NREQ][$];
  int            hold[NREQ];
  int            loaded[NREQ];
  bit            rnd_valid, rnd_read, reader_en;
  int            occ;

  // reference: who owns the port, words this grant, where the next search starts
  bit m_busy;
  int m_owner, m_cnt, m_ptr;
  int glog[$];
  int wlog[$];
  int pushed[NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic load(input int r, input int n, input int base, input int stp, input bit last_end);
    for (int k = 0; k < n; k++) begin
      qd[r].push_back(DW'(base + k * stp));
      ql[r].push_back(last_end && (k == n - 1));
      loaded[r]++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = (qd[i].size() > 0) && (hold[i] == 0) &&
                         (!rnd_valid || $urandom_range(0, 3) != 0);
      bus.req_data[i]  = (qd[i].size() > 0) ? qd[i][0] : DW'($urandom);
      bus.req_last[i]  = (qd[i].size() > 0) ? ql[i][0] : 1'($urandom);
    end
    bus.wfull = (occ >= DEPTH);
  endtask

  // compare this cycle against the reference, then advance it across the edge
  task automatic step_model();
    logic [NREQ-1:0] er;
    bit ep, pop, found, l;
    ep = m_busy && bus.req_valid[m_owner] && !bus.wfull;
    er = (m_busy && !bus.wfull) ? (NREQ'(1) << m_owner) : '0;
    chk("busy", busy, m_busy);
    if (m_busy) chk("grant_id", grant_id, m_owner);
    chk("req_ready", bus.req_ready, er);
    chk("wpush", bus.wpush, ep);
    if (ep) chk("wdata", bus.wdata, qd[m_owner][0]);
    pop = reader_en && (occ > 0) && (!rnd_read || $urandom_range(0, 1) == 1);
    occ = occ + int'(bus.wpush) - int'(pop);
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && bus.req_valid[(m_ptr + k) % NREQ]) begin
          found   = 1;
          m_owner = (m_ptr + k) % NREQ;
        end
      end
      if (found) begin
        m_busy = 1;
        m_cnt  = 0;
        glog.push_back(m_owner);
        wlog.push_back(0);
      end
    end else if (ep) begin
      l = ql[m_owner][0];
      void'(qd[m_owner].pop_front());
      void'(ql[m_owner].pop_front());
      pushed[m_owner]++;
      wlog[wlog.size() - 1] = wlog[wlog.size() - 1] + 1;
      m_cnt++;
      if (l || m_cnt == MB) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % NREQ;
      end
    end
    for (int i = 0; i < NREQ; i++) if (hold[i] > 0) hold[i]--;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge wclk);
      drive();
      #1;
      step_model();
    end
  endtask

  // asynchronous reset from wherever we are, check it bites at once, restart
  task automatic reset_all();
    wrst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_wpush", bus.wpush, 1'b0);
    chk("rst_ready", bus.req_ready, '0);
    chk("rst_gid", grant_id, 2'd0);
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; occ = 0;
    glog.delete(); wlog.delete();
    for (int i = 0; i < NREQ; i++) begin
      qd[i].delete(); ql[i].delete();
      hold[i] = 0; loaded[i] = 0; pushed[i] = 0;
    end
    drive();
    bus.req_data[0] = 8'h3C;
    #1;
    chk("rst_wdata", bus.wdata, 8'h3C);
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    int sum_l, sum_p;
    wrst_n    = 1'b1;
    rnd_valid = 0;
    rnd_read  = 0;
    reader_en = 1;
    occ       = 0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.wfull     = 1'b0;
    #2;
    reset_all();

    // single packet from requester 2, then search must start at 3
    load(2, 3, 5, 5, 1);
    run(5);
    chk("t1_grant", glog[0], 2);
    chk("t1_words", wlog[0], 3);
    chk("t1_busy_fall", busy, 1'b0);
    load(1, 1, 8'h11, 0, 1);
    load(3, 1, 8'h33, 0, 1);
    run(6);
    chk("t1_next3", glog[1], 3);
    chk("t1_then1", glog[2], 1);

    // all four valid, 2-word packets: strict 0,1,2,3,0 rotation
    reset_all();
    for (int r = 0; r < NREQ; r++)
      for (int p = 0; p < 3; p++) load(r, 2, r * 16 + p * 2, 1, 1);
    run(20);
    for (int k = 0; k < 5; k++) begin
      chk("t2_order", glog[k], k % NREQ);
      chk("t2_words", wlog[k], 2);
    end

    // long stream on 1 is chopped at MAX_BURST, 3 interleaves
    reset_all();
    load(1, 20, 8'h40, 1, 0);
    load(3, 2, 8'h80, 1, 1);
    load(3, 2, 8'h90, 1, 1);
    run(40);
    chk("t3_ngrants", glog.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("t3_order", glog[k], (k % 2 == 0) ? 1 : 3);
      chk("t3_words", wlog[k], (k == 4) ? 4 : ((k % 2 == 0) ? 8 : 2));
    end

    // stalled reader: 16 writes then the grant sits on wfull
    reset_all();
    reader_en = 0;
    load(0, 18, 0, 1, 1);
    run(30);
    chk("t4_pushed16", pushed[0], 16);
    chk("t4_wpush0", bus.wpush, 1'b0);
    chk("t4_ready0", bus.req_ready, '0);
    chk("t4_held", busy, 1'b1);
    reader_en = 1;
    run(20);
    chk("t4_pushed18", pushed[0], 18);
    chk("t4_drained", qd[0].size(), 0);

    // owner 1 goes quiet mid-packet, 2 must wait for req_last
    reset_all();
    load(1, 6, 8'hA0, 1, 1);
    load(2, 2, 8'hB0, 1, 1);
    run(3);
    hold[1] = 5;
    repeat (5) begin
      run(1);
      chk("t5_hold_gid", grant_id, 2'd1);
      chk("t5_hold_push", bus.wpush, 1'b0);
    end
    run(12);
    chk("t5_ngrants", glog.size(), 2);
    chk("t5_first", glog[0], 1);
    chk("t5_second", glog.size() > 1 ? glog[1] : -1, 2);
    chk("t5_words1", wlog[0], 6);

    // reset mid-grant on 2, arbitration restarts from 0
    reset_all();
    load(1, 2, 8'h10, 1, 1);
    load(2, 4, 8'h20, 1, 1);
    run(6);
    chk("t6_mid_gid", grant_id, 2'd2);
    reset_all();
    load(0, 1, 8'h01, 0, 1);
    load(3, 1, 8'h03, 0, 1);
    run(3);
    chk("t6_restart", glog[0], 0);

    // random traffic, random reader stalls
    reset_all();
    rnd_valid = 1;
    rnd_read  = 1;
    for (int r = 0; r < NREQ; r++)
      for (int p = 0; p < 8; p++)
        load(r, $urandom_range(1, 12), $urandom_range(0, 255), 1, 1);
    run(600);
    rnd_valid = 0;
    rnd_read  = 0;
    run(300);
    sum_l = 0;
    sum_p = 0;
    for (int r = 0; r < NREQ; r++) begin
      sum_l += loaded[r];
      sum_p += pushed[r];
      chk("t7_empty", qd[r].size(), 0);
    end
    chk("t7_total", sum_p, sum_l);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
